// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the bus master port
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        RWAIT = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } bus_state_t;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

endpackage

// File: rtl/bus_timeout_counter.sv
// rtl/bus_timeout_counter.sv - saturating watchdog counter with hold and clear
module bus_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    input  logic hold,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TOP  = CW'(TIMEOUT);

    logic [CW-1:0] count;
    logic          step;

    // A counted cycle that lands exactly on TIMEOUT is reported in that same
    // cycle so the owner can leave on the following edge.
    always_comb begin
        step    = enable && !hold;
        expired = step && (count == LAST);
    end

    // Wait-cycle counter; clear wins, hold freezes, saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (step && (count != TOP)) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/master_port.sv
// rtl/master_port.sv - parallel request to serial bus master handshake converter
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_mode,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mode,
    output logic                  wr_bus,
    output logic                  master_valid,
    output logic                  master_ready,
    input  logic                  rd_bus,
    input  logic                  slave_ready,
    input  logic                  slave_valid,
    input  logic                  split
);

    localparam int CNT_W = $clog2((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_A = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DATA_WIDTH - 1);

    bus_state_t            state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  err_q, err_nxt;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] addr_sh;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [DATA_WIDTH-1:0] rshift_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic load, addr_shift, data_shift, rd_shift, rd_last;
    logic tmo_en, tmo_hold, tmo_expired;

    // Watchdog only runs while waiting for the first address bit or for read
    // data; a split from the slave freezes it without losing the count.
    always_comb begin
        tmo_en   = ((state == ADDR) && (cnt == '0) && !slave_ready) ||
                   ((state == RWAIT) && !slave_valid);
        tmo_hold = (state == RWAIT) && split;
    end

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rstn    (rstn),
        .enable  (tmo_en),
        .hold    (tmo_hold),
        .clear   (load),
        .expired (tmo_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
        end
    end

    // Next-state, bit counter and datapath strobes.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        err_nxt    = err_q;
        load       = 1'b0;
        addr_shift = 1'b0;
        data_shift = 1'b0;
        rd_shift   = 1'b0;
        rd_last    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (slave_ready) begin
                    addr_shift = 1'b1;
                    if (cnt == LAST_A) begin
                        cnt_nxt   = '0;
                        state_nxt = (mode_q == MODE_WRITE) ? WDATA : RWAIT;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if ((cnt != '0) || tmo_expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end
            end
            WDATA: begin
                if (slave_ready) begin
                    data_shift = 1'b1;
                    if (cnt == LAST_D) begin
                        cnt_nxt   = '0;
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RWAIT: begin
                // Arriving data beats a watchdog expiring in the same cycle.
                if (slave_valid) begin
                    cnt_nxt   = '0;
                    state_nxt = RDATA;
                end else if (tmo_expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RDATA: begin
                if (slave_valid) begin
                    rd_shift = 1'b1;
                    if (cnt == LAST_D) begin
                        rd_last   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture and MSB-first shift registers for the outbound lines.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q   <= MODE_READ;
            addr_sh  <= '0;
            wdata_sh <= '0;
        end else if (load) begin
            mode_q   <= req_mode;
            addr_sh  <= req_addr;
            wdata_sh <= req_wdata;
        end else begin
            if (addr_shift) begin
                addr_sh <= {addr_sh[ADDR_WIDTH-2:0], 1'b0};
            end
            if (data_shift) begin
                wdata_sh <= {wdata_sh[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    // Read assembly; the visible response only changes when a read completes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rshift_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (rd_shift) begin
                rshift_q <= {rshift_q[DATA_WIDTH-2:0], rd_bus};
            end
            if (rd_last) begin
                rdata_q <= {rshift_q[DATA_WIDTH-2:0], rd_bus};
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        req_ready    = (state == IDLE);
        master_valid = (state == ADDR) || (state == WDATA);
        master_ready = (state == RDATA);
        mode         = ((state == IDLE) || (state == RESP)) ? 1'b0 : mode_q;
        wr_bus       = 1'b0;
        if (state == ADDR) begin
            wr_bus = addr_sh[ADDR_WIDTH-1];
        end else if (state == WDATA) begin
            wr_bus = wdata_sh[DATA_WIDTH-1];
        end
        rsp_valid    = (state == RESP);
        rsp_err      = (state == RESP) && err_q;
        rsp_rdata    = rdata_q;
    end

endmodule

// File: tb/tb_master_port.sv
// tb/tb_master_port.sv - randomized self-checking bench for master_port
module tb_master_port;
    import bus_pkg::*;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_mode = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          mode;
    logic          wr_bus;
    logic          master_valid;
    logic          master_ready;
    logic          rd_bus = 1'b0;
    logic          slave_ready = 1'b0;
    logic          slave_valid = 1'b0;
    logic          split = 1'b0;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_rdata = '0;

    always #5 clk = ~clk;

    master_port #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mode     (req_mode),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mode         (mode),
        .wr_bus       (wr_bus),
        .master_valid (master_valid),
        .master_ready (master_ready),
        .rd_bus       (rd_bus),
        .slave_ready  (slave_ready),
        .slave_valid  (slave_valid),
        .split        (split)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer. Cycle 0 presents the request; the slave follows a fixed
    // schedule: ready from cycle 1+a_wait for nbits cycles, split for s
    // cycles at RWAIT entry, then r_wait idle cycles, then data (with up to
    // max_gaps random stalls). Expected outcome is worked out from the rules.
    task automatic run_xfer(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input int a_wait, input int nbits, input int s, input int r_wait,
                            input logic [DW-1:0] rd, input int max_gaps);
        int             total, r0, v, t, rsp_t, rsp_cnt, ncap, gaps, bidx, rw_bad, took, exp_t;
        logic           exp_err, err_seen, rd_ok;
        logic [DW-1:0]  rdata_seen;
        logic [AW+DW-1:0] cap, exp_cap, full;

        total = (m == MODE_WRITE) ? AW + DW : AW;
        full  = (m == MODE_WRITE) ? {a, wd} : {{DW{1'b0}}, a};
        r0 = 1 + a_wait + AW;
        v  = r0 + s + r_wait;
        t = 0; rsp_t = -1; rsp_cnt = 0; ncap = 0; gaps = 0; bidx = 0; rw_bad = 0; took = 0;
        err_seen = 1'b0; rd_ok = 1'b0; rdata_seen = '0; cap = '0; exp_t = -1; exp_err = 1'b0;

        if (a_wait >= TMO) begin
            nbits = 0;
            exp_t = 1 + TMO;
            exp_err = 1'b1;
        end else if (nbits < total) begin
            exp_t = 2 + a_wait + nbits;
            exp_err = 1'b1;
        end else if (m == MODE_WRITE) begin
            exp_t = 1 + a_wait + total;
        end else if (a_wait + r_wait >= TMO) begin
            exp_t = r0 + s + TMO - a_wait;
            exp_err = 1'b1;
        end else begin
            rd_ok = 1'b1;
        end
        exp_cap = full >> (total - nbits);

        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_mode = m; req_addr = a; req_wdata = wd;
        while (t < 2000) begin
            @(posedge clk); #1; t++;
            req_valid = 1'b0;
            bidx += took;
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_t < 0) begin
                    rsp_t = t; err_seen = rsp_err; rdata_seen = rsp_rdata;
                    check("rsp_bus_idle", {master_valid, master_ready, wr_bus, mode}, 0);
                end
            end
            if (t == 1) begin
                check("master_valid_n1", master_valid, 1);
                check("mode_held", mode, m);
            end
            if (rsp_t >= 0 && t == rsp_t + 1) begin
                check("req_ready_after", req_ready, 1);
                break;
            end
            if (rd_ok && t >= r0 && t <= v && (master_valid || master_ready)) rw_bad++;
            slave_ready = (t >= 1 + a_wait) && (t < 1 + a_wait + nbits);
            if (slave_ready) begin
                cap = {cap[AW+DW-2:0], wr_bus};
                ncap++;
            end
            split = (m == MODE_READ) && (t >= r0) && (t < r0 + s);
            slave_valid = 1'b0;
            took = 0;
            if (m == MODE_READ && t >= v && bidx < DW) begin
                if (master_ready && gaps < max_gaps && $urandom_range(0, 3) == 0) gaps++;
                else slave_valid = 1'b1;
                rd_bus = rd[DW-1-bidx];
                took = (slave_valid && master_ready) ? 1 : 0;
            end
        end
        slave_ready = 1'b0; split = 1'b0; slave_valid = 1'b0; rd_bus = 1'b0;

        if (rd_ok) exp_t = v + 1 + DW + gaps;
        check("rsp_cycle", rsp_t, exp_t);
        check("rsp_count", rsp_cnt, 1);
        check("rsp_err", err_seen, exp_err);
        check("rsp_rdata", rdata_seen, rd_ok ? rd : exp_rdata);
        if (rd_ok) exp_rdata = rd;
        check("bits_taken", ncap, nbits);
        check("wr_bus_bits", cap, exp_cap);
        if (m == MODE_READ) check("rwait_quiet", rw_bad, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int cnt_rsp;
        logic m;
        int tot, nb;

        #3;
        check("rst_req_ready", req_ready, 1);
        check("rst_bus_outs", {master_valid, master_ready, wr_bus, mode, rsp_valid, rsp_err}, 0);
        check("rst_rdata", rsp_rdata, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Directed write, slave ready from cycle 2.
        run_xfer(MODE_WRITE, 16'h0025, 8'hA5, 1, AW + DW, 0, 0, 8'h00, 0);
        // Directed read, 5 wait cycles.
        run_xfer(MODE_READ, 16'h0010, 8'h00, 0, AW, 0, 5, 8'h3C, 0);
        // Long split, no timeout.
        run_xfer(MODE_READ, 16'hBEEF, 8'h00, 2, AW, 200, 3, 8'hFF, 0);
        // Slave never answers.
        run_xfer(MODE_WRITE, 16'h1234, 8'h56, 1000, AW + DW, 0, 0, 8'h00, 0);
        // Read data never arrives.
        run_xfer(MODE_READ, 16'h4321, 8'h00, 3, AW, 0, 200, 8'h77, 0);
        // Abort after 5 address bits.
        run_xfer(MODE_WRITE, 16'hF0F0, 8'h0F, 0, 5, 0, 0, 8'h00, 0);
        // Abort inside write data.
        run_xfer(MODE_WRITE, 16'h8001, 8'hC3, 2, AW + 3, 0, 0, 8'h00, 0);

        // Reset in the middle of write data.
        req_valid = 1'b1; req_mode = MODE_WRITE; req_addr = 16'hAAAA; req_wdata = 8'h55;
        @(posedge clk); #1;
        req_valid = 1'b0; slave_ready = 1'b1;
        repeat (19) @(posedge clk);
        #1 check("wdata_active", master_valid, 1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_bus", {master_valid, master_ready, wr_bus, mode, rsp_valid}, 0);
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_rdata", rsp_rdata, 0);
        exp_rdata = '0;
        slave_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        cnt_rsp = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) cnt_rsp++;
        end
        check("no_rsp_after_rst", cnt_rsp, 0);
        run_xfer(MODE_WRITE, 16'h5A5A, 8'h3C, 0, AW + DW, 0, 0, 8'h00, 0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            m   = $urandom_range(0, 1);
            tot = (m == MODE_WRITE) ? AW + DW : AW;
            nb  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, tot - 1) : tot;
            run_xfer(m, AW'($urandom), DW'($urandom), $urandom_range(0, 10), nb,
                     $urandom_range(0, 20), $urandom_range(0, 20), DW'($urandom), 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/master_port.md
# master_port

Bus-side master interface that converts a parallel local request (address, write data, read/write mode) into the serial address/data handshake consumed by the system bus slave ports, and collects serial read data back into a parallel response. It sits directly upstream of a slave port (or the bus interconnect in front of one), one instance per bus master. It handles write and read transfers, split waits, and a watchdog timeout.

## Interface
- ADDR_WIDTH, 16, address bits, shifted MSB first
- DATA_WIDTH, 8, data bits, shifted MSB first
- TIMEOUT, 64, max wait cycles for slave_ready (first address bit) or slave_valid (read data); split cycles excluded
- clk  in  1  clock; all logic rising-edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  local request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_mode  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  target address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse: transfer finished
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid on reads, holds until next read completes
- rsp_err  out  1  qualifies rsp_valid: 1 = timeout/abort
- mode  out  1  bus mode, held stable for the whole transfer
- wr_bus  out  1  serial address/write-data line
- master_valid  out  1  master driving a transfer
- master_ready  out  1  master accepting read bits
- rd_bus  in  1  serial read-data line
- slave_ready  in  1  slave sampling wr_bus this cycle
- slave_valid  in  1  slave presenting a read bit this cycle
- split  in  1  slave in split wait

## Operation
- States: IDLE, ADDR, WDATA, RWAIT, RDATA, RESP.
- IDLE: req_ready=1. req_valid&&req_ready latches addr/wdata/mode, clears bit counter and timeout counter → ADDR.
- ADDR: master_valid=1, mode=latched mode, wr_bus=addr[ADDR_WIDTH-1-cnt]. Each cycle with slave_ready=1: cnt+1. On the cycle cnt==ADDR_WIDTH-1 with slave_ready: cnt←0, → WDATA (write) or RWAIT (read).
- WDATA: master_valid=1, wr_bus=wdata[DATA_WIDTH-1-cnt], advance on slave_ready; last bit accepted → RESP, rsp_err=0. Further slave_ready cycles after the last bit are ignored.
- RWAIT: master_valid=0, master_ready=0. slave_valid=1 → RDATA (cnt←0).
- RDATA: master_ready=1; each cycle slave_valid&&master_ready shifts rd_bus into rdata LSB (MSB-first assembly), cnt+1; DATA_WIDTH-th bit → RESP, rsp_rdata updated.
- RESP: rsp_valid=1 for exactly one cycle, all bus outputs 0 → IDLE.
- Timeout counter: counts in ADDR while cnt==0 and slave_ready=0, and in RWAIT while split=0; reaching TIMEOUT → RESP with rsp_err=1, rsp_rdata unchanged. Held (not cleared) while split=1.
- Abort: slave_ready drops to 0 in ADDR (cnt>0) or WDATA → RESP with rsp_err=1 next cycle.
- Write RESP: rsp_rdata unchanged.

## Timing
- Reset (async assert): state IDLE, req_ready=1, all other outputs 0, rsp_rdata=0, counters 0.
- Reset mid-transfer: bus outputs drop immediately; no rsp_valid is issued for the aborted request.
- req accepted on edge N → master_valid high from cycle N+1.
- Write with slave_ready first seen at cycle S, never dropping: last data bit at S+ADDR_WIDTH+DATA_WIDTH-1, rsp_valid at S+ADDR_WIDTH+DATA_WIDTH.
- Read: rsp_valid the cycle after the DATA_WIDTH-th accepted bit.
- Back-to-back: req_ready returns the cycle after RESP; minimum request spacing = transfer + 2 cycles.
- Outputs req_ready, master_valid, master_ready, mode, wr_bus, rsp_valid: decoded from state/registers only, no combinational path from bus inputs.

## Structure
- Shared package bus_pkg: state enum type, MODE_WRITE=1 / MODE_READ=0 constants.
- One sub-module: bus_timeout_counter (enable, hold, clear, expired; width $clog2(TIMEOUT+1)).

## Test plan
- Write addr=0x0025 data=0xA5, slave_ready from cycle 2 → wr_bus 0000_0000_0010_0101 then 1010_0101, rsp_valid at cycle 26, rsp_err=0.
- Read addr=0x0010, slave returns 0x3C after 5 wait cycles → rsp_rdata=0x3C, rsp_err=0, master_valid low during RWAIT.
- Read with split high 200 cycles then data 0xFF → no timeout, rsp_rdata=0xFF.
- No slave response (slave_ready stuck 0) → rsp_valid with rsp_err=1 exactly TIMEOUT cycles after ADDR entry.
- slave_ready drops after 5 address bits → rsp_err=1 next cycle, master_valid 0, req_ready 1 after.
- rstn asserted mid-WDATA → all bus outputs 0 immediately, no rsp_valid; next write completes normally.
